// File: rtl/bsg_manycore_tile_loader.sv
// Host-side loader for one vanilla tile: freeze, set pc_init, stream program stores,
// wait for every store ack, then unfreeze. Store acks are tracked with a credit counter.
module bsg_manycore_tile_loader #(
  parameter int x_cord_width_p    = 4,
  parameter int y_cord_width_p    = 4,
  parameter int addr_width_p      = 16,
  parameter int data_width_p      = 32,
  parameter int max_out_credits_p = 32,
  parameter logic [addr_width_p-1:0] csr_freeze_addr_p  = '0,
  parameter logic [addr_width_p-1:0] csr_pc_init_addr_p = '0
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_v_i,
  input  logic [x_cord_width_p-1:0]     tgt_x_i,
  input  logic [y_cord_width_p-1:0]     tgt_y_i,
  input  logic [data_width_p-1:0]       pc_init_i,
  input  logic                          prog_v_i,
  input  logic [addr_width_p-1:0]       prog_addr_i,
  input  logic [data_width_p-1:0]       prog_data_i,
  input  logic                          prog_last_i,
  output logic                          prog_yumi_o,
  output logic                          out_v_o,
  output logic [addr_width_p-1:0]       out_addr_o,
  output logic [data_width_p-1:0]       out_data_o,
  output logic [(data_width_p/8)-1:0]   out_mask_o,
  output logic [x_cord_width_p-1:0]     out_x_o,
  output logic [y_cord_width_p-1:0]     out_y_o,
  input  logic                          out_credit_or_ready_i,
  input  logic                          returned_v_i,
  output logic                          returned_yumi_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int credit_width_lp = $clog2(max_out_credits_p + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FREEZE, S_PC, S_LOAD, S_DRAIN, S_UNFREEZE, S_FIN
  } state_e;

  state_e                      r_state;
  logic [credit_width_lp-1:0]  r_credits;
  logic [x_cord_width_p-1:0]   r_tgt_x;
  logic [y_cord_width_p-1:0]   r_tgt_y;
  logic [data_width_p-1:0]     r_pc_init;
  logic                        r_busy;
  logic                        r_done;

  logic                        w_credit_ok;
  logic                        w_pending;
  logic                        w_send;
  logic                        w_ack;
  logic [addr_width_p-1:0]     w_addr;
  logic [data_width_p-1:0]     w_data;

  assign w_credit_ok = (r_credits < credit_width_lp'(max_out_credits_p));

  // Packet source depends only on state; LOAD forwards the program stream directly.
  always_comb begin
    w_pending = 1'b0;
    w_addr    = prog_addr_i;
    w_data    = prog_data_i;
    case (r_state)
      S_FREEZE: begin
        w_pending = 1'b1;
        w_addr    = csr_freeze_addr_p;
        w_data    = {{(data_width_p-1){1'b0}}, 1'b1};
      end
      S_PC: begin
        w_pending = 1'b1;
        w_addr    = csr_pc_init_addr_p;
        w_data    = r_pc_init;
      end
      S_LOAD: w_pending = prog_v_i;
      S_UNFREEZE: begin
        w_pending = 1'b1;
        w_addr    = csr_freeze_addr_p;
        w_data    = '0;
      end
      default: w_pending = 1'b0;
    endcase
  end

  assign out_v_o         = w_pending & w_credit_ok;
  assign w_send          = out_v_o & out_credit_or_ready_i;
  assign prog_yumi_o     = w_send & (r_state == S_LOAD);
  assign out_addr_o      = w_addr;
  assign out_data_o      = w_data;
  assign out_mask_o      = '1;
  assign out_x_o         = r_tgt_x;
  assign out_y_o         = r_tgt_y;
  assign returned_yumi_o = returned_v_i;
  assign busy_o          = r_busy;
  assign done_o          = r_done;

  // A stray ack at zero credits is dropped so the counter cannot wrap.
  assign w_ack = returned_v_i & (r_credits != '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_credits <= '0;
    end else if (w_send & ~w_ack) begin
      r_credits <= r_credits + 1'b1;
    end else if (~w_send & w_ack) begin
      r_credits <= r_credits - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tgt_x   <= '0;
      r_tgt_y   <= '0;
      r_pc_init <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start_v_i) begin
          r_tgt_x   <= tgt_x_i;
          r_tgt_y   <= tgt_y_i;
          r_pc_init <= pc_init_i;
          r_done    <= 1'b0;
          r_busy    <= 1'b1;
          r_state   <= S_FREEZE;
        end
        S_FREEZE: if (w_send) r_state <= S_PC;
        S_PC:     if (w_send) r_state <= S_LOAD;
        S_LOAD:   if (w_send & prog_last_i) r_state <= S_DRAIN;
        S_DRAIN:  if (r_credits == '0) r_state <= S_UNFREEZE;
        S_UNFREEZE: if (w_send) begin
          r_busy  <= 1'b0;
          r_state <= S_FIN;
        end
        S_FIN: if (r_credits == '0) begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  a_no_stray_ack: assert property (@(posedge clk_i) disable iff (reset_i)
                                   !(returned_v_i && (r_credits == '0)));

endmodule

// File: tb/tb_bsg_manycore_tile_loader.sv
// Directed-random bench: acts as host and endpoint, predicts the packet stream and
// the credit-gated valid from a transaction-level model of the load sequence.
module tb_bsg_manycore_tile_loader;

  localparam int XW   = 4;
  localparam int YW   = 4;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int MAXC = 3;
  localparam logic [AW-1:0] FA = 16'h1000;
  localparam logic [AW-1:0] PA = 16'h1004;

  logic clk = 1'b0;
  logic reset_i, start_v_i, prog_v_i, prog_last_i, prog_yumi_o;
  logic [XW-1:0] tgt_x_i, out_x_o;
  logic [YW-1:0] tgt_y_i, out_y_o;
  logic [DW-1:0] pc_init_i, prog_data_i, out_data_o;
  logic [AW-1:0] prog_addr_i, out_addr_o;
  logic [DW/8-1:0] out_mask_o;
  logic out_v_o, out_credit_or_ready_i, returned_v_i, returned_yumi_o, busy_o, done_o;

  always #5 clk = ~clk;

  bsg_manycore_tile_loader #(
    .x_cord_width_p(XW), .y_cord_width_p(YW), .addr_width_p(AW), .data_width_p(DW),
    .max_out_credits_p(MAXC), .csr_freeze_addr_p(FA), .csr_pc_init_addr_p(PA)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_v_i(start_v_i),
    .tgt_x_i(tgt_x_i), .tgt_y_i(tgt_y_i), .pc_init_i(pc_init_i),
    .prog_v_i(prog_v_i), .prog_addr_i(prog_addr_i), .prog_data_i(prog_data_i),
    .prog_last_i(prog_last_i), .prog_yumi_o(prog_yumi_o),
    .out_v_o(out_v_o), .out_addr_o(out_addr_o), .out_data_o(out_data_o),
    .out_mask_o(out_mask_o), .out_x_o(out_x_o), .out_y_o(out_y_o),
    .out_credit_or_ready_i(out_credit_or_ready_i),
    .returned_v_i(returned_v_i), .returned_yumi_o(returned_yumi_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  int n_pass = 0;
  int n_total = 0;

  // Model state: one load sequence in terms of packets sent and acks outstanding.
  logic [AW-1:0] p_addr[$];
  logic [DW-1:0] p_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  int ack_q[$];
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  int n_words, p_idx, k, outstanding, cyc;
  int ready_pct, prog_pct, ack_lo, ack_hi, ack_budget;
  bit active, noise;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_inputs();
    out_credit_or_ready_i = ($urandom_range(99) < ready_pct);
    returned_v_i = 1'b0;
    if (ack_budget != 0 && ack_q.size() > 0 && ack_q[0] <= cyc) begin
      returned_v_i = 1'b1;
      void'(ack_q.pop_front());
      if (ack_budget > 0) ack_budget--;
    end
    if (p_idx < n_words) begin
      prog_v_i    = ($urandom_range(99) < prog_pct);
      prog_addr_i = p_addr[p_idx];
      prog_data_i = p_data[p_idx];
      prog_last_i = (p_idx == n_words - 1);
    end else begin
      prog_v_i = 1'b0; prog_addr_i = '0; prog_data_i = '0; prog_last_i = 1'b0;
    end
    start_v_i = noise && active && (k < 3 + n_words) && $urandom_range(1);
    tgt_x_i   = XW'($urandom);
    tgt_y_i   = YW'($urandom);
  endtask

  task automatic tick();
    bit send, ack, pend;
    @(negedge clk);
    ack = returned_v_i;
    chk("ret_yumi", returned_yumi_o, returned_v_i);
    if (active) begin
      pend = (k < 2) ? 1'b1 : prog_v_i;
      if (k < 2 + n_words)                       chk("out_v", out_v_o, pend && (outstanding < MAXC));
      else if (k == 2 + n_words && outstanding > 0) chk("drain_hold", out_v_o, 0);
      else if (k > 2 + n_words)                  chk("fin_quiet", out_v_o, 0);
      chk("busy", busy_o, k < 3 + n_words);
      if (k < 3 + n_words) chk("done_early", done_o, 0);
    end else begin
      chk("idle_out_v", out_v_o, 0);
    end
    send = out_v_o & out_credit_or_ready_i;
    chk("prog_yumi", prog_yumi_o, send && active && k >= 2 && k < 2 + n_words);
    if (send && active && exp_addr.size() > 0) begin
      chk("pkt_addr", out_addr_o, exp_addr.pop_front());
      chk("pkt_data", out_data_o, exp_data.pop_front());
      chk("pkt_xy", {out_x_o, out_y_o}, {cur_x, cur_y});
      chk("pkt_mask", out_mask_o, {(DW/8){1'b1}});
      if (k >= 2 && k < 2 + n_words) p_idx++;
      k++;
      ack_q.push_back(cyc + $urandom_range(ack_hi, ack_lo));
    end
    outstanding += int'(send) - int'(ack);
    if (active && done_o) begin
      chk("done_pkts", k, n_words + 3);
      chk("done_credits", outstanding, 0);
      active = 1'b0;
      noise  = 1'b0;
    end
    @(posedge clk); #1; cyc++;
    drive_inputs();
  endtask

  task automatic start_seq(int n);
    logic [DW-1:0] pc;
    n_words = n; p_idx = 0; k = 0;
    p_addr.delete(); p_data.delete(); exp_addr.delete(); exp_data.delete();
    pc = $urandom;
    cur_x = XW'($urandom); cur_y = YW'($urandom);
    exp_addr.push_back(FA); exp_data.push_back(32'd1);
    exp_addr.push_back(PA); exp_data.push_back(pc);
    for (int i = 0; i < n; i++) begin
      p_addr.push_back(AW'($urandom)); p_data.push_back($urandom);
      exp_addr.push_back(p_addr[i]); exp_data.push_back(p_data[i]);
    end
    exp_addr.push_back(FA); exp_data.push_back(32'd0);
    start_v_i = 1'b1; tgt_x_i = cur_x; tgt_y_i = cur_y; pc_init_i = pc;
    @(negedge clk);
    chk("start_idle_v", out_v_o, 0);
    @(posedge clk); #1; cyc++;
    active = 1'b1;
    drive_inputs();
    start_v_i = 1'b0;
  endtask

  task automatic run_to_done(int budget);
    int c = 0;
    while (active && c < budget) begin
      tick();
      c++;
    end
    chk("timeout", active, 0);
    active = 1'b0;
  endtask

  task automatic setup(int rdy, int pp, int lo, int hi);
    ready_pct = rdy; prog_pct = pp; ack_lo = lo; ack_hi = hi; ack_budget = -1;
  endtask

  initial begin
    cyc = 0; outstanding = 0; active = 0; noise = 0; n_words = 0; p_idx = 0; k = 0;
    setup(100, 100, 1, 1);
    reset_i = 1'b1; start_v_i = 0; tgt_x_i = 0; tgt_y_i = 0; pc_init_i = 0;
    prog_v_i = 0; prog_addr_i = 0; prog_data_i = 0; prog_last_i = 0;
    out_credit_or_ready_i = 1; returned_v_i = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_v", out_v_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_yumi", prog_yumi_o, 0);
    @(posedge clk); #1; reset_i = 1'b0;

    // 1: always ready, 1-cycle acks, 4 words
    setup(100, 100, 1, 1);
    start_seq(4);
    run_to_done(200);
    tick();
    chk("done_sticky", done_o, 1);

    // 2: acks withheld, valid drops at the credit limit; one ack buys one send
    setup(100, 100, 1, 1);
    ack_budget = 0;
    start_seq(6);
    repeat (MAXC + 4) tick();
    chk("stall_count", k, MAXC);
    ack_budget = 1;
    repeat (6) tick();
    chk("one_more", k, MAXC + 1);
    ack_budget = -1;
    run_to_done(300);

    // 3: steady send+ack in the same cycle near the limit
    setup(100, 100, 2, 2);
    start_seq(8);
    run_to_done(300);

    // 4: random ready/valid/ack timing, start and target noise while busy
    for (int r = 0; r < 4; r++) begin
      setup(50, 70, 1, 5);
      noise = 1'b1;
      start_seq(8);
      run_to_done(1000);
    end

    // 5: long ack delay holds the unfreeze store
    setup(100, 100, 10, 10);
    start_seq(3);
    run_to_done(300);

    // 6: reset in LOAD with acks outstanding, then a clean run
    setup(100, 100, 1, 1);
    ack_budget = 0;
    start_seq(6);
    for (int c = 0; c < 50 && k < MAXC; c++) tick();
    chk("pre_rst_k", k, MAXC);
    reset_i = 1'b1;
    @(posedge clk); #1; cyc++;
    reset_i = 1'b0;
    ack_q.delete(); active = 1'b0; outstanding = 0; ack_budget = -1;
    n_words = 0; p_idx = 0; k = 0;
    drive_inputs();
    @(negedge clk);
    chk("midrst_out_v", out_v_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_yumi", prog_yumi_o, 0);
    chk("midrst_done", done_o, 0);
    @(posedge clk); #1; cyc++;
    drive_inputs();
    start_seq(5);
    run_to_done(300);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
